// File: rtl/piso_serializer8_if.sv
// Handshake/data bundle between the upstream holding register and piso_serializer8.
// master drives the word and load strobe; slave (the serializer) drives the status outputs.
interface piso_serializer8_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] D;
  logic             ld_;
  logic             sout;
  logic             busy;
  logic             done;
  logic [3:0]       cnt;

  modport master (output D, ld_, input sout, busy, done, cnt);
  modport slave  (input D, ld_, output sout, busy, done, cnt);
endinterface

// File: rtl/piso_serializer8.sv
// Parallel-in/serial-out stage: captures D on ld_ low in IDLE and shifts it out MSB-first.
// Optional macro PISO_PARITY_EN appends an even-parity bit after the LSB.
module piso_serializer8 #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                clr,
  piso_serializer8_if.slave   bus
);

`ifdef PISO_PARITY_EN
  localparam int NB = WIDTH + 1;
`else
  localparam int NB = WIDTH;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state, state_nxt;
  logic [NB-1:0]   cap;
  logic [NB-1:0]   shreg;
  logic            sout_q;
  logic [3:0]      cnt_q;
  logic            last_bit;
  logic            busy_c, done_c;

  // The parity bit rides along as the lowest bit of the shift register.
`ifdef PISO_PARITY_EN
  assign cap = {bus.D, ^bus.D};
`else
  assign cap = bus.D;
`endif

  assign last_bit = (cnt_q == 4'd1);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= IDLE;
      shreg  <= '0;
      sout_q <= 1'b1;
      cnt_q  <= 4'd0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (!bus.ld_) begin
            shreg  <= cap;
            sout_q <= cap[NB-1];
            cnt_q  <= 4'(NB);
          end
        end
        SHIFT: begin
          if (last_bit) begin
            sout_q <= 1'b1;
            cnt_q  <= 4'd0;
          end else begin
            shreg  <= shreg << 1;
            sout_q <= shreg[NB-2];
            cnt_q  <= cnt_q - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!bus.ld_) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_c = 1'b0;
    done_c = 1'b0;
    case (state)
      SHIFT:   busy_c = 1'b1;
      DONE:    done_c = 1'b1;
      default: ;
    endcase
  end

  assign bus.sout = sout_q;
  assign bus.cnt  = cnt_q;
  assign bus.busy = busy_c;
  assign bus.done = done_c;

endmodule

// File: tb/tb_piso_serializer8.sv
// Scoreboard bench for piso_serializer8: stimulus pushes expected (bit, cnt) pairs,
// a negedge monitor pops and compares whenever busy is high.
module tb_piso_serializer8;
  localparam int WIDTH = 8;
`ifdef PISO_PARITY_EN
  localparam int NB = WIDTH + 1;
`else
  localparam int NB = WIDTH;
`endif
  localparam int PER = NB + 2;

  typedef struct packed {
    logic       b;
    logic [3:0] c;
  } exp_t;

  logic clk = 1'b0;
  logic clr;

  piso_serializer8_if #(.WIDTH(WIDTH)) bus ();
  piso_serializer8 #(.WIDTH(WIDTH)) dut (.clk(clk), .clr(clr), .bus(bus));

  always #5 clk = ~clk;

  exp_t       exp_q[$];
  int         done_cyc[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc    = 0;
  bit         mon_en = 1'b0;
  logic       prev_busy = 1'b0;
  logic [3:0] prev_cnt  = 4'd0;
  exp_t       e;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Expected serial stream: hand-written bit pattern (MSB first) plus its parity bit.
  task automatic push_word(input logic [7:0] bits, input logic par);
    for (int k = 0; k < WIDTH; k++) exp_q.push_back('{b: bits[WIDTH-1-k], c: 4'(NB - k)});
`ifdef PISO_PARITY_EN
    exp_q.push_back('{b: par, c: 4'd1});
`endif
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      cyc++;
      if (bus.busy === 1'b1) begin
        if (exp_q.size() == 0) check("unexpected_bit", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          check("sout", 32'(bus.sout), 32'(e.b));
          check("cnt", 32'(bus.cnt), 32'(e.c));
        end
      end else begin
        check("idle_sout", 32'(bus.sout), 32'd1);
        check("idle_cnt", 32'(bus.cnt), 32'd0);
      end
      if (bus.done === 1'b1) begin
        done_cyc.push_back(cyc);
        check("done_after_last", 32'({prev_busy, bus.busy, prev_cnt}), 32'({1'b1, 1'b0, 4'd1}));
      end else if (prev_busy === 1'b1 && bus.busy !== 1'b1) begin
        check("missing_done", 32'd0, 32'd1);
      end
      prev_busy = bus.busy;
      prev_cnt  = bus.cnt;
    end
  end

  // An aborted transfer legitimately ends without a done pulse.
  always @(posedge clr) prev_busy = 1'b0;

  task automatic load(input logic [7:0] word, input logic par);
    bus.D   = word;
    bus.ld_ = 1'b0;
    push_word(word, par);
    @(posedge clk);
    #1 bus.ld_ = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bus.busy !== 1'b0 || bus.done !== 1'b0 || exp_q.size() != 0) && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_timeout", 32'(n < 60), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sout"}, 32'(bus.sout), 32'd1);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_cnt"},  32'(bus.cnt),  32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nd;
    bus.D   = 8'h00;
    bus.ld_ = 1'b1;
    clr     = 1'b1;
    #3 check_reset_outputs("rst_during");
    #7 clr = 1'b0;
    #1 check_reset_outputs("rst_after");
    @(posedge clk);
    #1 mon_en = 1'b1;
    check_reset_outputs("rst_idle");

    // Basic load: 10101010, even parity 0.
    nd = done_cyc.size();
    load(8'b10101010, 1'b0);
    wait_idle();
    check("basic_done_count", 32'(done_cyc.size() - nd), 32'd1);

    // Captured word must survive D change and a stray ld_ pulse mid-shift.
    nd = done_cyc.size();
    load(8'b11001100, 1'b0);
    @(posedge clk);
    #1 begin bus.D = 8'b11111111; bus.ld_ = 1'b0; end
    @(posedge clk);
    #1 bus.ld_ = 1'b1;
    wait_idle();
    repeat (PER) @(posedge clk);
    #1 check("stable_done_count", 32'(done_cyc.size() - nd), 32'd1);
    check("stable_no_reload", 32'(exp_q.size()), 32'd0);

    // Mid-shift reset after three bits, then reload straight out of reset.
    nd = done_cyc.size();
    load(8'b11110000, 1'b0);
    repeat (2) @(posedge clk);
    #6 clr = 1'b1;
    #1 check_reset_outputs("midrst_now");
    exp_q.delete();
    @(posedge clk);
    #1 check_reset_outputs("midrst_hold");
    clr = 1'b0;
    load(8'b00000001, 1'b1);
    wait_idle();
    check("midrst_done_count", 32'(done_cyc.size() - nd), 32'd1);

    // Back-to-back: ld_ held low for three transfers.
    nd = done_cyc.size();
    bus.D   = 8'b10000001;
    bus.ld_ = 1'b0;
    for (int i = 0; i < 3; i++) push_word(8'b10000001, 1'b0);
    repeat (2 * PER + 1) @(posedge clk);
    #1 bus.ld_ = 1'b1;
    wait_idle();
    check("b2b_done_count", 32'(done_cyc.size() - nd), 32'd3);
    if (done_cyc.size() - nd == 3) begin
      check("b2b_spacing1", 32'(done_cyc[nd+1] - done_cyc[nd]), 32'(PER));
      check("b2b_spacing2", 32'(done_cyc[nd+2] - done_cyc[nd+1]), 32'(PER));
    end

    repeat (4) @(posedge clk);
    #1 check_reset_outputs("final_idle");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
